// File: rtl/store_buffer.sv
// Posted-write store buffer between the pipeline memory stage and data memory.
// Stores drain in program order; loads may forward from the youngest buffered word store.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic                     st_byte,
   input  logic                     drain_en,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hit,
   output logic [31:0]              ld_data,
   output logic                     ld_conflict,
   output logic                     mem_we,
   output logic                     mem_sb,
   output logic [31:0]              mem_a,
   output logic [31:0]              mem_wd,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]      addr_q [DEPTH];
   logic [31:0]      addr_d [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [DEPTH-1:0] sb_q;
   logic [DEPTH-1:0] sb_d;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [PW-1:0]    idx_s;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic             unused_s;

   // Ready ignores a same-cycle pop on purpose: no full-bypass path.
   assign full_s   = (count_q == CW'(DEPTH));
   assign push_s   = st_valid && !full_s;
   assign pop_s    = drain_en && (count_q != {CW{1'b0}});
   assign unused_s = ^ld_addr[1:0];

   assign st_ready = !full_s;
   assign empty    = (count_q == {CW{1'b0}});
   assign count    = count_q;
   assign mem_we   = pop_s;
   assign mem_sb   = sb_q[rd_ptr_q];
   assign mem_a    = addr_q[rd_ptr_q];
   assign mem_wd   = data_q[rd_ptr_q];

   // Next-state for entry storage, pointers and occupancy.
   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      sb_d     = sb_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         addr_d[wr_ptr_q] = st_addr;
         data_d[wr_ptr_q] = st_data;
         sb_d[wr_ptr_q]   = st_byte;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Load lookup: walk from oldest to youngest so the youngest match wins.
   always_comb begin
      ld_hit      = 1'b0;
      ld_conflict = 1'b0;
      ld_data     = 32'h0;
      idx_s       = {PW{1'b0}};
      for (int age = DEPTH - 1; age >= 0; age--) begin
         idx_s = wr_ptr_q - PW'(age) - PW'(1);
         if ((CW'(age) < count_q) && (addr_q[idx_s][31:2] == ld_addr[31:2])) begin
            ld_hit      = !sb_q[idx_s];
            ld_conflict = sb_q[idx_s];
            ld_data     = sb_q[idx_s] ? 32'h0 : data_q[idx_s];
         end else begin
            ld_data = ld_data;
         end
      end
   end

   // State registers; entry RAM is cleared too so mem_* read 0 out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 32'h0;
            data_q[i] <= 32'h0;
         end
         sb_q     <= {DEPTH{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         sb_q     <= sb_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
